fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised instruction-fetch front end with a prefetch queue, sitting between instruction memory and the Decode stage of the pipelined core. It issues in-order fetch requests over a valid/ready handshake, tolerates variable memory latency, and buffers up to DEPTH instructions so Decode stalls do not stall memory. It implements the `trigger` start gate. It also implements redirect-flush for taken branches and jumps, including discard of stale in-flight responses.

## Interface
- `XLEN`, 32: address/PC width.
- `DEPTH`, 4: queue slots; power of two, ≥2.
- `RESET_PC`, 0: PC loaded at reset.
- `CW`, $clog2(DEPTH+1): counter width (derived, not overridden).

- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `trigger`  in  1  start gate; fetching begins the cycle after `trigger` is first sampled high.
- `redirect_valid`  in  1  flush and restart at `redirect_pc` (taken branch/jump from Execute).
- `redirect_pc`  in  XLEN  new fetch address.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_addr`  out  XLEN  fetch address.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_rsp_valid`  in  1  in-order response valid.
- `imem_rsp_data`  in  32  instruction word.
- `instr_valid`  out  1  head instruction available.
- `instr`  out  32  head instruction.
- `instr_pc`  out  XLEN  PC of head instruction.
- `instr_pc_plus4`  out  XLEN  `instr_pc` + 4, modulo 2^XLEN.
- `instr_ready`  in  1  Decode accepts (low = Stall).
- `count`  out  CW  slots allocated (filled or awaiting response).
- `running`  out  1  trigger latched.

## Operation
- State: `pc` register; circular slot array {pc, data, filled}, with head/tail pointers of width $clog2(DEPTH) plus a wrap bit; `alloc` count; `inflight` count; `drop` count; `running` flag.
- Start gate: `running` sets when `trigger`=1 and is sticky until reset. While `running`=0, `imem_req_valid`=0.
- Issue: `imem_req_valid` = `running` & !`redirect_valid` & (`alloc` + `drop` < DEPTH), with `imem_req_addr` = `pc`.
  - On valid&ready: allocate tail slot with pc (filled=0), tail++, `inflight`++, `pc` += 4 (wraps modulo 2^XLEN).
- Response: on `imem_rsp_valid`:
  - If `drop` > 0: discard the response and decrement `drop`.
  - Else: write data into the oldest unfilled slot, set filled=1, and decrement `inflight`.
  - A response with `inflight`=0 and `drop`=0 is ignored.
- Output: `instr_valid` = head slot allocated & filled. Outputs are driven from registered slot storage.
- Dequeue: on `instr_valid` & `instr_ready`, free the head slot and increment head.
- Redirect (priority over everything):
  - Free all slots; head = tail.
  - `drop` += `inflight` (a response in the same cycle belongs to the old stream and is consumed from that total).
  - `inflight` = 0; `pc` = `redirect_pc`.
  - A dequeue in the same cycle is ignored.
  - A redirect while `running`=0 updates `pc` only.
- Invariant: `alloc` + `drop` ≤ DEPTH at all times, which bounds total outstanding memory requests to DEPTH.

## Timing
- Reset values:
  - `imem_req_valid`=0, `imem_req_addr`=RESET_PC.
  - `instr_valid`=0, `instr`=0, `instr_pc`=0, `instr_pc_plus4`=4.
  - `count`=0, `running`=0.
  - All internal counters and pointers 0.
- `trigger` high in cycle T makes `imem_req_valid` high in T+1.
- Back-to-back issue at one request per cycle while `imem_req_ready`=1 and a slot is free.
- `imem_req_addr` is held stable while valid & !ready, unless a redirect occurs.
- Response captured in cycle N gives `instr_valid` in N+1 if that slot is head. Minimum request-to-Decode latency is 2 cycles with a 1-cycle memory.
- Full: `alloc`=DEPTH drops `imem_req_valid` in the same cycle. A dequeue frees a slot visible to issue the next cycle; there is no same-cycle bypass.
- Redirect in cycle R: `imem_req_valid`=0 and `instr_valid` is still valid in cycle R. From R+1, `instr_valid`=0, `count`=0, and requests start from `redirect_pc` if `alloc`+`drop`<DEPTH.
- An asynchronous reset mid-operation clears everything immediately, including `drop`. Memory is reset with the block.

## Test plan
- Reset then `trigger` pulse, 1-cycle memory, `instr_ready`=1 -> addresses 0,4,8,… issued on consecutive cycles; `instr_pc` 0,4,8 with `instr_pc_plus4` 4,8,12; first `instr_valid` 2 cycles after first request.
- DEPTH=4, `instr_ready`=0 -> exactly 4 requests issued, `count`=4, `imem_req_valid`=0; raising `instr_ready` for 1 cycle -> 1 dequeue, next request the following cycle at 0x10.
- Memory latency 3 cycles, 3 requests in flight, redirect to 0x100 -> next 3 responses discarded; first delivered `instr_pc`=0x100 carries data of the 4th response.
- Redirect and dequeue in the same cycle, queue holding pc 0x20 at head -> 0x20 is not counted as delivered; next `instr_pc`=redirect target.
- `imem_req_ready` held low 5 cycles -> `imem_req_addr` constant; `pc` advances by exactly 4 on acceptance.
- `pc`=0xFFFF_FFFC with XLEN=32 -> next request address 0x0; `instr_pc_plus4`=0x0 for that instruction.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction prefetch queue with start gate and redirect flush.
module fetch_queue #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            trigger,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pc_plus4,
  input  logic            instr_ready,
  output logic [CW-1:0]   count,
  output logic            running
);
  localparam int AW = $clog2(DEPTH);
  logic [XLEN-1:0] pc;
  logic [AW:0] head, tail, fill_ptr;
  logic [CW-1:0] alloc, inflight, drop;
  logic [CW:0] outstanding;
  logic [XLEN-1:0] slot_pc [DEPTH];
  logic [31:0] slot_data [DEPTH];
  logic [DEPTH-1:0] slot_filled;
  logic fire_req, rsp_drop, rsp_fill, deq;
  assign alloc = CW'(tail - head);
  assign outstanding = {1'b0, alloc} + {1'b0, drop};
  // responses return in order, so the oldest unfilled slot sits inflight entries behind tail
  assign fill_ptr = tail - (AW + 1)'(inflight);
  assign imem_req_valid = running & ~redirect_valid & (outstanding < (CW + 1)'(DEPTH));
  assign imem_req_addr = pc;
  assign fire_req = imem_req_valid & imem_req_ready;
  assign rsp_drop = imem_rsp_valid & (drop != '0);
  assign rsp_fill = imem_rsp_valid & (drop == '0) & (inflight != '0);
  assign instr_valid = (alloc != '0) & slot_filled[head[AW-1:0]];
  assign instr = slot_data[head[AW-1:0]];
  assign instr_pc = slot_pc[head[AW-1:0]];
  assign instr_pc_plus4 = instr_pc + XLEN'(4);
  assign deq = instr_valid & instr_ready & ~redirect_valid;
  assign count = alloc;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_PC;
      head <= '0;
      tail <= '0;
      inflight <= '0;
      drop <= '0;
      running <= 1'b0;
      slot_filled <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_pc[i] <= '0;
        slot_data[i] <= '0;
      end
    end else begin
      if (trigger) running <= 1'b1;
      if (redirect_valid) begin
        pc <= redirect_pc;
        head <= tail;
        inflight <= '0;
        // a same-cycle response is the oldest of the old stream
        drop <= drop + inflight - CW'(imem_rsp_valid && (drop != '0 || inflight != '0));
      end else begin
        if (fire_req) begin
          pc <= pc + XLEN'(4);
          tail <= tail + 1'b1;
          slot_pc[tail[AW-1:0]] <= pc;
          slot_filled[tail[AW-1:0]] <= 1'b0;
        end
        if (deq) head <= head + 1'b1;
        if (rsp_drop) drop <= drop - 1'b1;
        inflight <= inflight + CW'(fire_req) - CW'(rsp_fill);
        if (rsp_fill) begin
          slot_data[fill_ptr[AW-1:0]] <= imem_rsp_data;
          slot_filled[fill_ptr[AW-1:0]] <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks of fetch_queue against a latency-configurable in-order memory.
module tb_fetch_queue;
  localparam logic [31:0] KEY = 32'hDEAD_BEEF;
  logic clk = 1'b0;
  logic reset, trigger, redirect_valid, req_valid, req_ready, rsp_valid;
  logic instr_valid, instr_ready, running;
  logic [31:0] redirect_pc, req_addr, rsp_data, instr, instr_pc, instr_pc_plus4;
  logic [2:0] count;
  int checks = 0, errors = 0, cyc = 0, lat = 1, issued = 0;
  logic [31:0] q_addr [$];
  int q_due [$];

  fetch_queue dut (
    .clk(clk), .reset(reset), .trigger(trigger),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(req_valid), .imem_req_addr(req_addr), .imem_req_ready(req_ready),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_pc_plus4(instr_pc_plus4), .instr_ready(instr_ready),
    .count(count), .running(running)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one clock cycle: drive memory response, sample handshakes, advance to next negedge
  task automatic step();
    logic hs, rf;
    logic [31:0] a;
    if (q_addr.size() > 0 && q_due[0] <= cyc) begin
      rsp_valid = 1'b1;
      rsp_data = q_addr[0] ^ KEY;
    end else begin
      rsp_valid = 1'b0;
      rsp_data = '0;
    end
    #1;
    hs = req_valid && req_ready;
    a = req_addr;
    rf = rsp_valid;
    @(posedge clk);
    if (rf) begin
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end
    if (hs) begin
      q_addr.push_back(a);
      q_due.push_back(cyc + lat);
      issued++;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    trigger = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    req_ready = 1'b1;
    rsp_valid = 1'b0;
    rsp_data = '0;
    instr_ready = 1'b0;
    q_addr.delete();
    q_due.delete();
    issued = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  task automatic wait_valid(input string tag);
    for (int k = 0; k < 20 && !instr_valid; k++) step();
    chk(tag, instr_valid, 1);
  endtask

  initial begin
    do_reset();
    reset = 1'b0;
    #1;
    chk("rst req_valid", req_valid, 0);
    chk("rst req_addr", req_addr, 0);
    chk("rst instr_valid", instr_valid, 0);
    chk("rst instr", instr, 0);
    chk("rst instr_pc", instr_pc, 0);
    chk("rst pc_plus4", instr_pc_plus4, 4);
    chk("rst count", count, 0);
    chk("rst running", running, 0);

    do_reset();
    lat = 1;
    instr_ready = 1'b1;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    chk("t1 running", running, 1);
    chk("t1 req_valid", req_valid, 1);
    chk("t1 addr0", req_addr, 0);
    step();
    chk("t1 addr4", req_addr, 4);
    chk("t1 no early valid", instr_valid, 0);
    step();
    chk("t1 first valid", instr_valid, 1);
    chk("t1 pc0", instr_pc, 0);
    chk("t1 data0", instr, 32'h0 ^ KEY);
    chk("t1 plus4 4", instr_pc_plus4, 4);
    chk("t1 addr8", req_addr, 8);
    step();
    chk("t1 pc4", instr_pc, 4);
    chk("t1 plus4 8", instr_pc_plus4, 8);
    step();
    chk("t1 pc8", instr_pc, 8);
    chk("t1 plus4 12", instr_pc_plus4, 12);

    do_reset();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    repeat (6) step();
    chk("t2 issued", issued, 4);
    chk("t2 count full", count, 4);
    chk("t2 req_valid full", req_valid, 0);
    chk("t2 head valid", instr_valid, 1);
    chk("t2 head pc", instr_pc, 0);
    instr_ready = 1'b1;
    #1;
    chk("t2 no bypass", req_valid, 0);
    step();
    instr_ready = 1'b0;
    #1;
    chk("t2 count after deq", count, 3);
    chk("t2 req_valid after deq", req_valid, 1);
    chk("t2 addr 0x10", req_addr, 32'h10);
    chk("t2 next head", instr_pc, 4);

    do_reset();
    lat = 3;
    instr_ready = 1'b1;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    repeat (3) step();
    chk("t3 inflight count", count, 3);
    chk("t3 none delivered", instr_valid, 0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    #1;
    chk("t3 req blocked", req_valid, 0);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("t3 count flushed", count, 0);
    chk("t3 valid flushed", instr_valid, 0);
    chk("t3 req restart", req_valid, 1);
    chk("t3 addr target", req_addr, 32'h100);
    wait_valid("t3 delivered");
    chk("t3 first pc", instr_pc, 32'h100);
    chk("t3 first data", instr, 32'h100 ^ KEY);
    #2;
    reset = 1'b0;
    #1;
    chk("async count", count, 0);
    chk("async req_valid", req_valid, 0);
    chk("async instr_valid", instr_valid, 0);
    chk("async running", running, 0);

    do_reset();
    lat = 1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h20;
    #1;
    step();
    redirect_valid = 1'b0;
    chk("t4 idle running", running, 0);
    chk("t4 idle req", req_valid, 0);
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    chk("t4 addr 0x20", req_addr, 32'h20);
    repeat (6) step();
    chk("t4 count", count, 4);
    chk("t4 head pc", instr_pc, 32'h20);
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    #1;
    chk("t4 valid in R", instr_valid, 1);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("t4 count flushed", count, 0);
    chk("t4 valid flushed", instr_valid, 0);
    wait_valid("t4 delivered");
    chk("t4 next pc", instr_pc, 32'h200);

    do_reset();
    lat = 1;
    req_ready = 1'b0;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t5 addr held", req_addr, 0);
      step();
    end
    chk("t5 still valid", req_valid, 1);
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    chk("t5 addr +4", req_addr, 4);
    chk("t5 one accept", issued, 1);

    do_reset();
    lat = 1;
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    #1;
    step();
    redirect_valid = 1'b0;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    chk("t6 addr top", req_addr, 32'hFFFF_FFFC);
    step();
    chk("t6 addr wrap", req_addr, 0);
    step();
    chk("t6 valid", instr_valid, 1);
    chk("t6 pc top", instr_pc, 32'hFFFF_FFFC);
    chk("t6 plus4 wrap", instr_pc_plus4, 0);
    step();
    chk("t6 pc wrapped", instr_pc, 0);
    chk("t6 plus4 4", instr_pc_plus4, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
